// File: rtl/sub_shift_rows.sv
// rtl/sub_shift_rows.sv - AES SubBytes + ShiftRows stage, iterative S-box bank, valid/ready output hold
// One bank of BYTES_PER_CYCLE S-boxes walks the working state chunk by chunk; the permuted result is held for mixColumns.
module sub_shift_rows #(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int N     = 16 / BYTES_PER_CYCLE;
  localparam int CW    = 8 * BYTES_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  // Forward S-box, entry x at bits [2047-8x -: 8]
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    S_IDLE,
    S_SUB,
    S_HOLD
  } state_t;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TABLE[{~x, 3'b111} -: 8];
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o[127 - 8 * (r + 4 * c) -: 8] = s[127 - 8 * (r + 4 * ((c + r) % 4)) -: 8];
      end
    end
    return o;
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [127:0]       work_q, work_d;
  logic               out_valid_q, out_valid_d;
  logic [127:0]       out_data_q, out_data_d;

  logic [CW-1:0]      chunk_in;
  logic [CW-1:0]      chunk_out;
  logic [127:0]       work_sub;
  logic               last;
  logic               accept;

  assign in_ready  = (state_q == S_IDLE) | ((state_q == S_HOLD) & out_ready);
  assign accept    = in_valid & in_ready;
  assign last      = (cnt_q == CNT_W'(N - 1));
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != S_IDLE);

  // Select the current chunk, run it through the shared S-box bank, merge it back
  always_comb begin
    chunk_in  = '0;
    chunk_out = '0;
    for (int k = 0; k < N; k++) begin
      if (cnt_q == CNT_W'(k)) chunk_in = work_q[127 - k * CW -: CW];
    end
    for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
      chunk_out[CW - 1 - 8 * j -: 8] = sbox(chunk_in[CW - 1 - 8 * j -: 8]);
    end
    work_sub = work_q;
    for (int k = 0; k < N; k++) begin
      if (cnt_q == CNT_W'(k)) work_sub[127 - k * CW -: CW] = chunk_out;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    work_d      = work_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          work_d  = in_data;
          cnt_d   = '0;
          state_d = S_SUB;
        end
      end
      S_SUB: begin
        work_d = work_sub;
        if (last) begin
          cnt_d       = '0;
          out_data_d  = shift_rows(work_sub);
          out_valid_d = 1'b1;
          state_d     = S_HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        // A new state may be taken on the same edge the result leaves
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (accept) begin
            work_d  = in_data;
            cnt_d   = '0;
            state_d = S_SUB;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      work_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_sub_shift_rows.sv
// tb/tb_sub_shift_rows.sv - directed bench for sub_shift_rows with a queue scoreboard and GF(2^8) reference model
module tb_sub_shift_rows;

  localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] ZERO_OUT = 128'h63636363636363636363636363636363;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_valid1, in_valid16;
  logic         out_ready;
  logic [127:0] in_data;
  logic         in_ready, out_valid, busy;
  logic [127:0] out_data;
  logic         in_ready1, out_valid1, busy1;
  logic [127:0] out_data1;
  logic         in_ready16, out_valid16, busy16;
  logic [127:0] out_data16;

  always #5 clk = ~clk;

  sub_shift_rows #(.BYTES_PER_CYCLE(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  sub_shift_rows #(.BYTES_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .busy(busy1)
  );

  sub_shift_rows #(.BYTES_PER_CYCLE(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16), .in_data(in_data),
    .out_valid(out_valid16), .out_ready(out_ready), .out_data(out_data16), .busy(busy16)
  );

  int           n_vec  = 0;
  int           n_fail = 0;
  int           cyc    = 0;
  logic [127:0] sb_q[$];

  function automatic logic [7:0] gf_mul(input logic [7:0] a_i, input logic [7:0] b_i);
    logic [7:0] a, b, p;
    a = a_i;
    b = b_i;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254, then the affine map
  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] v;
    v = 8'h01;
    for (int i = 0; i < 254; i++) v = gf_mul(v, x);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s);
    logic [7:0]   sb [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) sb[i] = sbox_ref(s[127 - 8 * i -: 8]);
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o[127 - 8 * (r + 4 * c) -: 8] = sb[r + 4 * ((c + r) % 4)];
      end
    end
    return o;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: scoreboard bookkeeping before the edge, then sample point 1 unit after it
  task automatic step();
    #1;
    if (rst) begin
      sb_q.delete();
    end else begin
      if (in_valid && in_ready) sb_q.push_back(model(in_data));
      if (out_valid && out_ready) begin
        check("sb_pending", 128'(sb_q.size() != 0), 128'd1);
        if (sb_q.size() != 0) check("sb_out_data", out_data, sb_q.pop_front());
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int           lat;
    logic [127:0] held, va, vb;

    rst        = 1'b1;
    in_valid   = 1'b0;
    in_valid1  = 1'b0;
    in_valid16 = 1'b0;
    out_ready  = 1'b1;
    in_data    = '0;
    step();
    step();
    rst = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);

    // FIPS-197 round 1
    in_valid = 1'b1;
    in_data  = FIPS_IN;
    step();
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom, $urandom, $urandom};
    wait_out(lat);
    check("t1_latency", lat, 4);
    check("t1_out_data", out_data, FIPS_OUT);
    step();
    check("t1_one_cycle", out_valid, 0);

    // All-zero state, busy through SUB and HOLD
    in_valid = 1'b1;
    in_data  = '0;
    step();
    in_valid = 1'b0;
    check("t2_busy_sub", busy, 1);
    wait_out(lat);
    check("t2_latency", lat, 4);
    check("t2_busy_hold", busy, 1);
    check("t2_out_data", out_data, ZERO_OUT);
    step();
    check("t2_busy_idle", busy, 0);

    // Backpressure for 10 cycles with a competing input
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = {$urandom, $urandom, $urandom, $urandom};
    step();
    in_valid = 1'b0;
    wait_out(lat);
    check("t3_latency", lat, 4);
    held = out_data;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      step();
      check("t3_valid_stable", out_valid, 1);
      check("t3_data_stable", out_data, held);
      check("t3_in_ready_low", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    check("t3_in_ready_release", in_ready, 1);
    step();
    check("t3_handshake_drop", out_valid, 0);
    step();
    check("t3_no_repeat", out_valid, 0);
    check("t3_sb_empty", 128'(sb_q.size()), 0);

    // Back-to-back with in_valid held
    va       = {$urandom, $urandom, $urandom, $urandom};
    vb       = {$urandom, $urandom, $urandom, $urandom};
    in_valid = 1'b1;
    in_data  = va;
    step();
    in_data = vb;
    wait_out(lat);
    check("t4_first_latency", lat, 4);
    check("t4_first_data", out_data, model(va));
    check("t4_in_ready_hold", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("t4_second_in_flight", busy, 1);
    wait_out(lat);
    check("t4_spacing", lat, 4);
    check("t4_second_data", out_data, model(vb));
    step();
    check("t4_sb_empty", 128'(sb_q.size()), 0);

    // Reset during the second SUB cycle
    in_valid = 1'b1;
    in_data  = FIPS_IN;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_out_valid", out_valid, 0);
    check("t5_out_data", out_data, 0);
    check("t5_in_ready", in_ready, 1);
    check("t5_busy", busy, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      check("t5_no_stale", out_valid, 0);
    end
    in_valid = 1'b1;
    in_data  = FIPS_IN;
    step();
    in_valid = 1'b0;
    wait_out(lat);
    check("t5_rerun_latency", lat, 4);
    check("t5_rerun_data", out_data, FIPS_OUT);
    step();

    // BYTES_PER_CYCLE = 1
    in_valid1 = 1'b1;
    in_data   = FIPS_IN;
    step();
    in_valid1 = 1'b0;
    lat = 0;
    while (!out_valid1 && lat < 40) begin
      step();
      lat++;
    end
    check("t6_bpc1_latency", lat, 16);
    check("t6_bpc1_data", out_data1, FIPS_OUT);
    step();
    check("t6_bpc1_drop", out_valid1, 0);

    // BYTES_PER_CYCLE = 16
    in_valid16 = 1'b1;
    in_data    = FIPS_IN;
    step();
    in_valid16 = 1'b0;
    lat = 0;
    while (!out_valid16 && lat < 40) begin
      step();
      lat++;
    end
    check("t6_bpc16_latency", lat, 1);
    check("t6_bpc16_data", out_data16, FIPS_OUT);
    step();
    check("t6_bpc16_drop", out_valid16, 0);

    check("final_sb_drained", 128'(sb_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
